gol_gen_scheduler: RTL

//  Sequences the Game-of-Life grid: issues the seed-load pulse, and advances

---
 rtl/gol_pkg.sv | 16 +
 rtl/gol_gen_scheduler_if.sv | 42 ++++
 rtl/gol_frame_tick.sv | 50 +++++
 rtl/gol_gen_scheduler.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/gol_pkg.sv
// Shared types and defaults for the Game-of-Life generation scheduler.
// Optional feature macro used across this slice: GOL_GEN_LIMIT_EN.
package gol_pkg;

    localparam int GOL_GEN_W_DEFAULT = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_PAUSED,
        S_RUN,
        S_STEP,
        S_WAIT
    } gol_sched_state_t;

endpackage

// File: rtl/gol_gen_scheduler_if.sv
// Control/grid bundle of the generation scheduler.
// slave  = the scheduler itself, master = board controls plus grid side.
// Optional macro GOL_GEN_LIMIT_EN adds gen_limit / limit_hit.
interface gol_gen_scheduler_if
    import gol_pkg::*;
#(
    parameter int GEN_W = GOL_GEN_W_DEFAULT
);
    logic             cmd_load;
    logic             cmd_run;
    logic             cmd_pause;
    logic             cmd_step;
    logic             vsync_in;
    logic             step_done;
    logic             load;
    logic             step_en;
    logic             running;
    logic             busy;
    logic [GEN_W-1:0] gen_count;
`ifdef GOL_GEN_LIMIT_EN
    logic [GEN_W-1:0] gen_limit;
    logic             limit_hit;

    modport slave (
        input  cmd_load, cmd_run, cmd_pause, cmd_step, vsync_in, step_done, gen_limit,
        output load, step_en, running, busy, gen_count, limit_hit
    );
    modport master (
        output cmd_load, cmd_run, cmd_pause, cmd_step, vsync_in, step_done, gen_limit,
        input  load, step_en, running, busy, gen_count, limit_hit
    );
`else
    modport slave (
        input  cmd_load, cmd_run, cmd_pause, cmd_step, vsync_in, step_done,
        output load, step_en, running, busy, gen_count
    );
    modport master (
        output cmd_load, cmd_run, cmd_pause, cmd_step, vsync_in, step_done,
        input  load, step_en, running, busy, gen_count
    );
`endif
endinterface

// File: rtl/gol_frame_tick.sv
// Frame boundary detector and RUN-mode rate divider.
// frame_tick pulses once per frame, when the registered vsync enters its active
// level; div_wrap marks the tick on which RATE_DIV counted frames complete.
module gol_frame_tick #(
    parameter int RATE_DIV         = 30,
    parameter int VSYNC_ACTIVE_LOW = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic vsync_in,
    input  logic div_en,
    input  logic div_clr,
    output logic frame_tick,
    output logic div_wrap
);
    localparam int                DIV_W    = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(RATE_DIV - 1);
    localparam logic              ACTIVE   = (VSYNC_ACTIVE_LOW != 0) ? 1'b0 : 1'b1;

    logic             vs_q;
    logic             vs_prev;
    logic [DIV_W-1:0] div;
    logic             div_last;

    assign frame_tick = (vs_q == ACTIVE) && (vs_prev != ACTIVE);
    assign div_last   = (div == DIV_LAST);
    assign div_wrap   = frame_tick && div_en && div_last;

    // Register vsync and keep one cycle of history for the edge detect.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values.
        if (rst) begin
            vs_q    <= 1'b0;
            vs_prev <= 1'b0;
        end else begin
            vs_q    <= vsync_in;
            vs_prev <= vs_q;
        end
    end

    // Count frame ticks while running; held at zero whenever div_clr is high.
    always_ff @(posedge clk) begin
        if (rst || div_clr) begin
            div <= '0;
        end else if (frame_tick && div_en) begin
            div <= div_last ? '0 : div + 1'b1;
        end
    end

endmodule

// File: rtl/gol_gen_scheduler.sv
// Game-of-Life generation scheduler: seed load, run/pause/single-step,
// with every generation step aligned to a VGA frame boundary.
// Optional macro GOL_GEN_LIMIT_EN: auto-pause when gen_count reaches gen_limit.
module gol_gen_scheduler
    import gol_pkg::*;
#(
    parameter int GEN_W            = GOL_GEN_W_DEFAULT,
    parameter int RATE_DIV         = 30,
    parameter int LOAD_CYCLES      = 1,
    parameter int VSYNC_ACTIVE_LOW = 1
) (
    input logic              clk,
    input logic              rst,
    gol_gen_scheduler_if.slave bus
);
    localparam int               LC_W    = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;
    localparam logic [LC_W-1:0]  LC_LAST = LC_W'(LOAD_CYCLES - 1);

    gol_sched_state_t state;
    logic             single;
    logic             step_arm;
    logic             pause_pend;
    logic             load_pend;
    logic [LC_W-1:0]  load_cnt;
    logic [GEN_W-1:0] gen_count;
    logic [GEN_W-1:0] gen_next;
    logic             load_q;
    logic             step_en_q;
    logic             running_q;
    logic             busy_q;
    logic             frame_tick;
    logic             div_wrap;
    logic             div_en;
    logic             div_clr;
    logic             load_req;
    logic             pause_req;
    logic             limit_now;

    // The divider only advances in RUN and restarts from zero on every RUN entry.
    assign div_en    = (state == S_RUN);
    assign div_clr   = (state == S_IDLE) || (state == S_LOAD) || (state == S_PAUSED);
    assign gen_next  = (gen_count == '1) ? gen_count : gen_count + 1'b1;
    assign load_req  = load_pend | bus.cmd_load;
    assign pause_req = pause_pend | bus.cmd_pause;

`ifdef GOL_GEN_LIMIT_EN
    logic limit_hit_q;
    assign limit_now     = (bus.gen_limit != '0) && (gen_next == bus.gen_limit);
    assign bus.limit_hit = limit_hit_q;
`else
    assign limit_now = 1'b0;
`endif

    assign bus.load      = load_q;
    assign bus.step_en   = step_en_q;
    assign bus.running   = running_q;
    assign bus.busy      = busy_q;
    assign bus.gen_count = gen_count;

    gol_frame_tick #(
        .RATE_DIV         (RATE_DIV),
        .VSYNC_ACTIVE_LOW (VSYNC_ACTIVE_LOW)
    ) u_frame_tick (
        .clk        (clk),
        .rst        (rst),
        .vsync_in   (bus.vsync_in),
        .div_en     (div_en),
        .div_clr    (div_clr),
        .frame_tick (frame_tick),
        .div_wrap   (div_wrap)
    );

    // Scheduler FSM; outputs are registered alongside each state transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            single     <= 1'b0;
            step_arm   <= 1'b0;
            pause_pend <= 1'b0;
            load_pend  <= 1'b0;
            load_cnt   <= '0;
            gen_count  <= '0;
            load_q     <= 1'b0;
            step_en_q  <= 1'b0;
            running_q  <= 1'b0;
            busy_q     <= 1'b0;
`ifdef GOL_GEN_LIMIT_EN
            limit_hit_q <= 1'b0;
`endif
        end else begin
            step_en_q <= 1'b0;
`ifdef GOL_GEN_LIMIT_EN
            limit_hit_q <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (bus.cmd_load) begin
                        state     <= S_LOAD;
                        load_q    <= 1'b1;
                        load_cnt  <= '0;
                        gen_count <= '0;
                        busy_q    <= 1'b1;
                    end
                end
                S_LOAD: begin
                    // Also clears a count that was bumped by the step finishing
                    // just before a deferred load.
                    gen_count <= '0;
                    if (load_cnt == LC_LAST) begin
                        state  <= S_PAUSED;
                        load_q <= 1'b0;
                        busy_q <= 1'b0;
                    end else begin
                        load_cnt <= load_cnt + 1'b1;
                    end
                end
                S_PAUSED: begin
                    if (bus.cmd_load) begin
                        state     <= S_LOAD;
                        load_q    <= 1'b1;
                        load_cnt  <= '0;
                        gen_count <= '0;
                        busy_q    <= 1'b1;
                        step_arm  <= 1'b0;
                    end else if (step_arm && frame_tick) begin
                        state     <= S_STEP;
                        step_en_q <= 1'b1;
                        busy_q    <= 1'b1;
                        single    <= 1'b1;
                        step_arm  <= 1'b0;
                    end else if (bus.cmd_step) begin
                        step_arm <= 1'b1;
                    end else if (bus.cmd_run) begin
                        state     <= S_RUN;
                        running_q <= 1'b1;
                        step_arm  <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (bus.cmd_load) begin
                        state     <= S_LOAD;
                        load_q    <= 1'b1;
                        load_cnt  <= '0;
                        gen_count <= '0;
                        busy_q    <= 1'b1;
                        running_q <= 1'b0;
                    end else if (bus.cmd_pause) begin
                        state     <= S_PAUSED;
                        running_q <= 1'b0;
                    end else if (div_wrap) begin
                        state     <= S_STEP;
                        step_en_q <= 1'b1;
                        busy_q    <= 1'b1;
                        single    <= 1'b0;
                    end
                end
                S_STEP: begin
                    state      <= S_WAIT;
                    pause_pend <= pause_req;
                    load_pend  <= load_req;
                end
                S_WAIT: begin
                    if (!bus.step_done) begin
                        pause_pend <= pause_req;
                        load_pend  <= load_req;
                    end else begin
                        gen_count  <= gen_next;
                        pause_pend <= 1'b0;
                        load_pend  <= 1'b0;
                        if (load_req) begin
                            state     <= S_LOAD;
                            load_q    <= 1'b1;
                            load_cnt  <= '0;
                            running_q <= 1'b0;
                        end else if (limit_now) begin
                            state     <= S_PAUSED;
                            busy_q    <= 1'b0;
                            running_q <= 1'b0;
`ifdef GOL_GEN_LIMIT_EN
                            limit_hit_q <= 1'b1;
`endif
                        end else if (single || pause_req) begin
                            state     <= S_PAUSED;
                            busy_q    <= 1'b0;
                            running_q <= 1'b0;
                        end else begin
                            state     <= S_RUN;
                            busy_q    <= 1'b0;
                            running_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
